// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD ALU front end: opcode map, legality limits,
// default field widths and the decoded-instruction record.
package simd_pkg;

    localparam int unsigned DEF_OPC_W  = 4;
    localparam int unsigned DEF_MODE_W = 3;
    localparam int unsigned DEF_IMM_W  = 8;
    localparam int unsigned DEF_INST_W = DEF_OPC_W + DEF_MODE_W + 1 + DEF_IMM_W;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [DEF_OPC_W-1:0] {
        OPC_NOP      = 4'd0,
        OPC_PADD     = 4'd1,
        OPC_PSUB     = 4'd2,
        OPC_PMUL     = 4'd3,
        OPC_PAND     = 4'd4,
        OPC_POR      = 4'd5,
        OPC_PXOR     = 4'd6,
        OPC_PSHIFT   = 4'd7,
        OPC_PUNPKLO  = 4'd8,
        OPC_PUNPKGHI = 4'd9
    } simd_opc_e;

    // Highest legal opcode and data mode; anything above decodes to NOP.
    localparam int unsigned SIMD_MAX_OPC  = 9;
    localparam int unsigned SIMD_MAX_MODE = 5;

    // Decoded instruction at the default field widths.
    typedef struct packed {
        logic [DEF_OPC_W-1:0]  opcode;
        logic [DEF_MODE_W-1:0] data_mode;
        logic                  imm_flag;
        logic [DEF_IMM_W-1:0]  imm;
        logic                  illegal;
    } simd_dec_t;

    // Occupancy of the output/skid register pair.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/simd_decode_logic.sv
// Combinational field split of a raw SIMD instruction word. Encodings with an
// out-of-range opcode or data mode are replaced by an immediate-form NOP and
// flagged as illegal.
module simd_decode_logic
    import simd_pkg::*;
#(
    parameter int unsigned OPC_W    = DEF_OPC_W,
    parameter int unsigned MODE_W   = DEF_MODE_W,
    parameter int unsigned IMM_W    = DEF_IMM_W,
    parameter int unsigned INST_W   = DEF_INST_W,
    parameter int unsigned MAX_OPC  = SIMD_MAX_OPC,
    parameter int unsigned MAX_MODE = SIMD_MAX_MODE
) (
    input  logic [INST_W-1:0] inst,
    output logic [OPC_W-1:0]  opcode,
    output logic [MODE_W-1:0] data_mode,
    output logic              imm_flag,
    output logic [IMM_W-1:0]  imm,
    output logic              illegal
);

    localparam int unsigned FLAG_POS = IMM_W;
    localparam int unsigned MODE_LSB = IMM_W + 1;

    logic [OPC_W-1:0]  raw_opc;
    logic [MODE_W-1:0] raw_mode;
    logic              raw_flag;
    logic [IMM_W-1:0]  raw_imm;
    logic              bad;

    // Split fields MSB first and substitute the NOP encoding for illegal words.
    always_comb begin
        raw_opc  = inst[INST_W-1 -: OPC_W];
        raw_mode = inst[MODE_LSB +: MODE_W];
        raw_flag = inst[FLAG_POS];
        raw_imm  = inst[IMM_W-1:0];
        bad      = (raw_opc > OPC_W'(MAX_OPC)) || (raw_mode > MODE_W'(MAX_MODE));

        if (bad) begin
            opcode    = '0;
            data_mode = '0;
            imm_flag  = 1'b1;
            imm       = '0;
            illegal   = 1'b1;
        end else begin
            opcode    = raw_opc;
            data_mode = raw_mode;
            imm_flag  = raw_flag;
            imm       = raw_imm;
            illegal   = 1'b0;
        end
    end

endmodule

// File: rtl/simd_decode_stage.sv
// Registered, valid/ready handshaked decode stage in front of SIMD ALU issue.
// An output register backed by one skid register lets in_ready depend only on
// local state. Illegal words are counted (saturating) and latched in a sticky
// flag; optionally, words that decode to NOP are consumed without being issued.
module simd_decode_stage
    import simd_pkg::*;
#(
    parameter int unsigned OPC_W      = DEF_OPC_W,
    parameter int unsigned MODE_W     = DEF_MODE_W,
    parameter int unsigned IMM_W      = DEF_IMM_W,
    parameter int unsigned INST_W     = DEF_INST_W,
    parameter int unsigned MAX_OPC    = SIMD_MAX_OPC,
    parameter int unsigned MAX_MODE   = SIMD_MAX_MODE,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SQUASH_NOP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [MODE_W-1:0] data_mode,
    output logic              imm_flag,
    output logic [IMM_W-1:0]  imm,
    output logic              illegal,
    output logic              illegal_seen,
    output logic [CNT_W-1:0]  illegal_cnt,
    input  logic              clr_stat
);

    if (INST_W != OPC_W + MODE_W + 1 + IMM_W) begin : g_width_check
        $error("simd_decode_stage: INST_W must equal OPC_W+MODE_W+1+IMM_W");
    end

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [MODE_W-1:0] data_mode;
        logic              imm_flag;
        logic [IMM_W-1:0]  imm;
        logic              illegal;
    } dec_t;

    logic [OPC_W-1:0]  dec_opcode;
    logic [MODE_W-1:0] dec_data_mode;
    logic              dec_imm_flag;
    logic [IMM_W-1:0]  dec_imm;
    logic              dec_illegal;
    dec_t              dec;

    occ_e              occ_q, occ_d;
    dec_t              out_q, out_d;
    dec_t              skid_q, skid_d;
    logic              illegal_seen_q, illegal_seen_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    logic              accept;
    logic              squash;
    logic              store;
    logic              drain;

    simd_decode_logic #(
        .OPC_W    (OPC_W),
        .MODE_W   (MODE_W),
        .IMM_W    (IMM_W),
        .INST_W   (INST_W),
        .MAX_OPC  (MAX_OPC),
        .MAX_MODE (MAX_MODE)
    ) u_decode (
        .inst      (inst),
        .opcode    (dec_opcode),
        .data_mode (dec_data_mode),
        .imm_flag  (dec_imm_flag),
        .imm       (dec_imm),
        .illegal   (dec_illegal)
    );

    // Handshake qualifiers and the occupancy / register-pair next state.
    always_comb begin
        dec.opcode    = dec_opcode;
        dec.data_mode = dec_data_mode;
        dec.imm_flag  = dec_imm_flag;
        dec.imm       = dec_imm;
        dec.illegal   = dec_illegal;

        accept = in_valid && (occ_q != OCC_FULL);
        squash = (SQUASH_NOP != 0) && (dec.opcode == '0);
        store  = accept && !squash;
        drain  = (occ_q != OCC_EMPTY) && out_ready;

        occ_d  = occ_q;
        out_d  = out_q;
        skid_d = skid_q;

        unique case (occ_q)
            OCC_EMPTY: begin
                if (store) begin
                    out_d = dec;
                    occ_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (drain && store) begin
                    out_d = dec;
                end else if (drain) begin
                    occ_d = OCC_EMPTY;
                end else if (store) begin
                    skid_d = dec;
                    occ_d  = OCC_FULL;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only the skid promotion can happen.
                if (drain) begin
                    out_d = skid_q;
                    occ_d = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // Illegal-word statistics; a clear beats a coincident illegal accept.
    always_comb begin
        illegal_seen_d = illegal_seen_q;
        illegal_cnt_d  = illegal_cnt_q;
        if (clr_stat) begin
            illegal_seen_d = 1'b0;
            illegal_cnt_d  = '0;
        end else if (accept && dec.illegal) begin
            illegal_seen_d = 1'b1;
            if (illegal_cnt_q != '1) begin
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q          <= OCC_EMPTY;
            out_q          <= '0;
            skid_q         <= '0;
            illegal_seen_q <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            occ_q          <= occ_d;
            out_q          <= out_d;
            skid_q         <= skid_d;
            illegal_seen_q <= illegal_seen_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign in_ready     = (occ_q != OCC_FULL);
    assign out_valid    = (occ_q != OCC_EMPTY);
    assign opcode       = out_q.opcode;
    assign data_mode    = out_q.data_mode;
    assign imm_flag     = out_q.imm_flag;
    assign imm          = out_q.imm;
    assign illegal      = out_q.illegal;
    assign illegal_seen = illegal_seen_q;
    assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_simd_decode_stage.sv
// Bench for simd_decode_stage: three instances (defaults, 2-bit counter,
// NOP squashing) against a FIFO-of-decoded-words reference model.
module tb_simd_decode_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  iv, ordy, clr;
    logic [15:0] win [3];

    logic [2:0]  o_inr, o_val, o_flag, o_ill, o_seen;
    logic [3:0]  o_opc  [3];
    logic [2:0]  o_mode [3];
    logic [7:0]  o_imm  [3];
    logic [15:0] o_cnt_a, o_cnt_c;
    logic [1:0]  o_cnt_b;

    int total = 0;
    int bad   = 0;

    // Reference model: up to two pending decoded words per instance,
    // packed as {opcode, mode, flag, imm, illegal}.
    logic [16:0] mq [3][2];
    int          mn    [3];
    int          mcnt  [3];
    bit          mseen [3];
    int          cmax  [3];
    bit          msq   [3];

    simd_decode_stage u_dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(o_inr[0]), .inst(win[0]),
        .out_valid(o_val[0]), .out_ready(ordy[0]), .opcode(o_opc[0]), .data_mode(o_mode[0]),
        .imm_flag(o_flag[0]), .imm(o_imm[0]), .illegal(o_ill[0]), .illegal_seen(o_seen[0]),
        .illegal_cnt(o_cnt_a), .clr_stat(clr[0])
    );

    simd_decode_stage #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(o_inr[1]), .inst(win[1]),
        .out_valid(o_val[1]), .out_ready(ordy[1]), .opcode(o_opc[1]), .data_mode(o_mode[1]),
        .imm_flag(o_flag[1]), .imm(o_imm[1]), .illegal(o_ill[1]), .illegal_seen(o_seen[1]),
        .illegal_cnt(o_cnt_b), .clr_stat(clr[1])
    );

    simd_decode_stage #(.SQUASH_NOP(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(o_inr[2]), .inst(win[2]),
        .out_valid(o_val[2]), .out_ready(ordy[2]), .opcode(o_opc[2]), .data_mode(o_mode[2]),
        .imm_flag(o_flag[2]), .imm(o_imm[2]), .illegal(o_ill[2]), .illegal_seen(o_seen[2]),
        .illegal_cnt(o_cnt_c), .clr_stat(clr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_dec(input logic [15:0] w);
        int unsigned v, opc, mode, flag, im;
        v    = w;
        opc  = v / 4096;
        mode = (v / 512) % 8;
        flag = (v / 256) % 2;
        im   = v % 256;
        if (opc > 9 || mode > 5) return {4'd0, 3'd0, 1'b1, 8'd0, 1'b1};
        return {opc[3:0], mode[2:0], flag[0], im[7:0], 1'b0};
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        if (i == 0) return 32'(o_cnt_a);
        if (i == 1) return 32'(o_cnt_b);
        return 32'(o_cnt_c);
    endfunction

    function automatic logic [16:0] fields_of(input int i);
        return {o_opc[i], o_mode[i], o_flag[i], o_imm[i], o_ill[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i]    = 0;
            mcnt[i]  = 0;
            mseen[i] = 1'b0;
        end
    endtask

    task automatic set_in(input int i, input bit v, input logic [15:0] w, input bit r, input bit c);
        iv[i]   = v;
        win[i]  = w;
        ordy[i] = r;
        clr[i]  = c;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    // Advance the model with the current inputs, then clock the DUTs.
    task automatic step();
        logic [16:0] d;
        bit acc, drn;
        for (int i = 0; i < 3; i++) begin
            d   = ref_dec(win[i]);
            acc = iv[i] && (mn[i] < 2);
            drn = (mn[i] > 0) && ordy[i];
            if (drn) begin
                mq[i][0] = mq[i][1];
                mn[i]--;
            end
            if (acc && !(msq[i] && d[16:13] == 4'd0)) begin
                mq[i][mn[i]] = d;
                mn[i]++;
            end
            if (clr[i]) begin
                mcnt[i]  = 0;
                mseen[i] = 1'b0;
            end else if (acc && d[0]) begin
                mseen[i] = 1'b1;
                if (mcnt[i] < cmax[i]) mcnt[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s/dut%0d/in_ready", tag, i), 32'(o_inr[i]), 32'(mn[i] < 2));
            chk($sformatf("%s/dut%0d/out_valid", tag, i), 32'(o_val[i]), 32'(mn[i] > 0));
            if (mn[i] > 0)
                chk($sformatf("%s/dut%0d/fields", tag, i), 32'(fields_of(i)), 32'(mq[i][0]));
            chk($sformatf("%s/dut%0d/seen", tag, i), 32'(o_seen[i]), 32'(mseen[i]));
            chk($sformatf("%s/dut%0d/cnt", tag, i), cnt_of(i), 32'(mcnt[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s/dut%0d/fields_zero", tag, i), 32'(fields_of(i)), 32'd0);
            chk($sformatf("%s/dut%0d/in_ready", tag, i), 32'(o_inr[i]), 32'd1);
            chk($sformatf("%s/dut%0d/out_valid", tag, i), 32'(o_val[i]), 32'd0);
        end
    endtask

    initial begin
        cmax[0] = 65535; cmax[1] = 3;    cmax[2] = 65535;
        msq[0]  = 1'b0;  msq[1]  = 1'b0; msq[2]  = 1'b1;
        model_reset();
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        check_all("reset");
        rst = 1'b0;

        // Legal word.
        set_in(0, 1'b1, 16'h1A05, 1'b1, 1'b0);
        step();
        idle_all();
        check_all("legal");
        chk("legal/opcode", 32'(o_opc[0]), 32'd1);
        chk("legal/mode", 32'(o_mode[0]), 32'd5);
        chk("legal/flag", 32'(o_flag[0]), 32'd0);
        chk("legal/imm", 32'(o_imm[0]), 32'h05);
        chk("legal/illegal", 32'(o_ill[0]), 32'd0);
        chk("legal/valid", 32'(o_val[0]), 32'd1);
        step();
        check_all("legal_drain");

        // Illegal opcode, then illegal mode.
        set_in(0, 1'b1, 16'hC1FF, 1'b1, 1'b0);
        step();
        check_all("ill_opc");
        chk("ill_opc/fields", 32'(fields_of(0)), 32'({4'd0, 3'd0, 1'b1, 8'd0, 1'b1}));
        set_in(0, 1'b1, 16'h1C05, 1'b1, 1'b0);
        step();
        idle_all();
        check_all("ill_mode");
        chk("ill_mode/fields", 32'(fields_of(0)), 32'({4'd0, 3'd0, 1'b1, 8'd0, 1'b1}));
        chk("ill_mode/cnt", cnt_of(0), 32'd2);
        chk("ill_mode/seen", 32'(o_seen[0]), 32'd1);
        step();

        // Back-pressure: two words fill the stage, the third waits.
        set_in(0, 1'b1, 16'h1201, 1'b0, 1'b0); step(); check_all("stall1");
        set_in(0, 1'b1, 16'h2402, 1'b0, 1'b0); step(); check_all("stall2");
        chk("stall2/in_ready", 32'(o_inr[0]), 32'd0);
        set_in(0, 1'b1, 16'h3603, 1'b0, 1'b0); step(); check_all("stall3");
        chk("stall3/opcode", 32'(o_opc[0]), 32'd1);
        step(); check_all("stall4");
        chk("stall4/imm", 32'(o_imm[0]), 32'h01);
        chk("stall4/in_ready", 32'(o_inr[0]), 32'd0);
        set_in(0, 1'b1, 16'h3603, 1'b1, 1'b0); step(); check_all("release1");
        chk("release1/opcode", 32'(o_opc[0]), 32'd2);
        step(); check_all("release2");
        chk("release2/opcode", 32'(o_opc[0]), 32'd3);
        idle_all();
        step(); check_all("release3");

        // 2-bit counter saturation, then clear against an illegal accept.
        for (int k = 0; k < 6; k++) begin
            set_in(1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
            step();
            check_all("sat");
        end
        chk("sat/cnt", cnt_of(1), 32'd3);
        set_in(1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        step();
        idle_all();
        check_all("clr");
        chk("clr/cnt", cnt_of(1), 32'd0);
        chk("clr/seen", 32'(o_seen[1]), 32'd0);
        step();

        // NOP squashing.
        set_in(2, 1'b1, 16'h0000, 1'b1, 1'b0); step(); check_all("sq_nop");
        chk("sq_nop/valid", 32'(o_val[2]), 32'd0);
        set_in(2, 1'b1, 16'hF000, 1'b1, 1'b0); step(); check_all("sq_ill");
        chk("sq_ill/valid", 32'(o_val[2]), 32'd0);
        set_in(2, 1'b1, 16'h1101, 1'b1, 1'b0); step(); check_all("sq_pass");
        chk("sq_pass/opcode", 32'(o_opc[2]), 32'd1);
        chk("sq_pass/cnt", cnt_of(2), 32'd1);
        idle_all();
        step();

        // Randomized traffic on all instances.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom % 4) != 0;
                ordy[i] = ($urandom % 2) != 0;
                win[i]  = 16'($urandom);
                clr[i]  = ($urandom % 32) == 0;
            end
            step();
            check_all("rand");
        end

        // Asynchronous reset with the stage full.
        idle_all();
        for (int k = 0; k < 3; k++) step();
        check_all("pre_fill");
        set_in(0, 1'b1, 16'hC1FF, 1'b0, 1'b0); step();
        set_in(0, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        check_all("full");
        chk("full/in_ready", 32'(o_inr[0]), 32'd0);
        iv[0] = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async/out_valid", 32'(o_val[0]), 32'd0);
        chk("async/in_ready", 32'(o_inr[0]), 32'd1);
        chk("async/cnt", cnt_of(0), 32'd0);
        chk("async/seen", 32'(o_seen[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("post_rst");
        check_all("post_rst");
        set_in(0, 1'b1, 16'h1A05, 1'b1, 1'b0);
        step();
        idle_all();
        check_all("after_rst");
        chk("after_rst/fields", 32'(fields_of(0)), 32'({4'd1, 3'd5, 1'b0, 8'h05, 1'b0}));
        step();
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
